// File: rtl/wb_sram_prefetcher_if.sv
// Wishbone B4 pipelined bus between the prefetcher (master) and the correlator bank (slave).
interface wb_sram_prefetcher_if #(
    parameter int WIDTH = 32,
    parameter int BYTES = 4,
    parameter int ABITS = 10
);
    logic             cyc_o;
    logic             stb_o;
    logic             we_o;
    logic             ack_i;
    logic             wat_i;
    logic             rty_i;
    logic             err_i;
    logic [ABITS-1:0] adr_o;
    logic [BYTES-1:0] sel_o;
    logic [WIDTH-1:0] dat_i;
    logic [WIDTH-1:0] dat_o;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  ack_i, wat_i, rty_i, err_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output ack_i, wat_i, rty_i, err_i, dat_i
    );
endinterface

// File: rtl/wb_sram_prefetcher.sv
// Block-prefetch engine: streams COUNT x BSIZE words from the correlator bank over a
// pipelined Wishbone read and copies each acked word into local SRAM at a linear index.
module wb_sram_prefetcher #(
    parameter int WIDTH = 32,
    parameter int BYTES = 4,
    parameter int USEBE = 1,
    parameter int ABITS = 10,
    parameter int COUNT = 24,
    parameter int CBITS = 5,
    parameter int BSIZE = 24,
    parameter int BBITS = 5,
    parameter int DELAY = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 begin_i,
    output logic                 ready_o,
    wb_sram_prefetcher_if.master wb,
    output logic                 sram_ce_o,
    output logic                 sram_we_o,
    output logic [ABITS-1:0]     sram_ad_o,
    output logic [BYTES-1:0]     sram_be_o,
    input  logic [WIDTH-1:0]     sram_do_i,
    output logic [WIDTH-1:0]     sram_di_o
);
    localparam int               TOTAL = COUNT * BSIZE;
    localparam logic [ABITS-1:0] LAST  = ABITS'(TOTAL - 1);
    localparam logic [BBITS-1:0] WLAST = BBITS'(BSIZE - 1);

    // S_FIN is the cycle in which the final SRAM write is on the port.
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIN} state_t;
    state_t r_state, w_next;

    logic             r_cyc, r_stb, r_ready, r_ce;
    logic [CBITS-1:0] r_blk;
    logic [BBITS-1:0] r_word;
    logic [ABITS-1:0] r_req_cnt, r_idx, r_ad;
    logic [WIDTH-1:0] r_di;
    logic             w_start, w_abort, w_req, w_ack, w_last_req, w_last_ack;
    logic             w_unused;

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_abort    = r_cyc & (wb.err_i | wb.rty_i);
        // err/rty wins over a simultaneous ack, so that word is never written
        w_ack      = r_cyc & wb.ack_i & ~w_abort;
        w_req      = r_stb & ~wb.wat_i & ~w_abort;
        w_last_req = w_req && (r_req_cnt == LAST);
        w_last_ack = w_ack && (r_idx == LAST);
        case (r_state)
            S_IDLE: if (begin_i) begin
                w_start = 1'b1;
                w_next  = S_BUSY;
            end
            S_BUSY: begin
                if (w_abort)         w_next = S_IDLE;
                else if (w_last_ack) w_next = S_FIN;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_ready   <= 1'b0;
            r_ce      <= 1'b0;
            r_blk     <= '0;
            r_word    <= '0;
            r_req_cnt <= '0;
            r_idx     <= '0;
            r_ad      <= '0;
            r_di      <= '0;
        end else begin
            r_ce <= 1'b0;
            if (w_start) begin
                r_ready   <= 1'b0;
                r_cyc     <= 1'b1;
                r_stb     <= 1'b1;
                r_blk     <= '0;
                r_word    <= '0;
                r_req_cnt <= '0;
                r_idx     <= '0;
            end else if (w_abort) begin
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
            end else begin
                if (w_req) begin
                    r_req_cnt <= r_req_cnt + 1'b1;
                    // address is left on the final word once the window is issued
                    if (w_last_req) begin
                        r_stb <= 1'b0;
                    end else if (r_word == WLAST) begin
                        r_word <= '0;
                        r_blk  <= r_blk + 1'b1;
                    end else begin
                        r_word <= r_word + 1'b1;
                    end
                end
                if (w_ack) begin
                    r_di  <= wb.dat_i;
                    r_ce  <= 1'b1;
                    r_ad  <= r_idx;
                    r_idx <= r_idx + 1'b1;
                    if (w_last_ack) r_cyc <= 1'b0;
                end
                if (r_state == S_FIN) r_ready <= 1'b1;
            end
        end
    end

    assign wb.cyc_o  = r_cyc;
    assign wb.stb_o  = r_stb;
    assign wb.we_o   = 1'b0;
    assign wb.adr_o  = {r_blk, r_word};
    assign wb.sel_o  = '1;
    assign wb.dat_o  = '0;

    assign ready_o   = r_ready;
    assign sram_ce_o = r_ce;
    assign sram_we_o = r_ce;
    assign sram_ad_o = r_ad;
    assign sram_di_o = r_di;
    assign sram_be_o = (USEBE != 0) ? {BYTES{r_ce}} : '1;

    // SRAM read port and the simulation delay parameter have no role in a write-only prefetch.
    assign w_unused  = ^{sram_do_i, DELAY[0]};
endmodule

// File: tb/tb_wb_sram_prefetcher.sv
// Directed bench: a small 2x3 instance for protocol corners and a default 24x24 instance.
module tb_wb_sram_prefetcher;
    logic        clk;
    logic        rst_s, rst_d, beg_s, beg_d;
    logic        ready_s, ready_d;
    logic        ce_s, we_s, ce_d, we_d;
    logic [9:0]  ad_s, ad_d;
    logic [3:0]  be_s, be_d;
    logic [31:0] di_s, di_d;
    int          checks = 0;
    int          errors = 0;

    wb_sram_prefetcher_if ws ();
    wb_sram_prefetcher_if wd ();

    wb_sram_prefetcher #(.COUNT(2), .BSIZE(3)) dut_s (
        .clk_i(clk), .rst_i(rst_s), .begin_i(beg_s), .ready_o(ready_s), .wb(ws),
        .sram_ce_o(ce_s), .sram_we_o(we_s), .sram_ad_o(ad_s), .sram_be_o(be_s),
        .sram_do_i(32'd0), .sram_di_o(di_s));

    wb_sram_prefetcher dut_d (
        .clk_i(clk), .rst_i(rst_d), .begin_i(beg_d), .ready_o(ready_d), .wb(wd),
        .sram_ce_o(ce_d), .sram_we_o(we_d), .sram_ad_o(ad_d), .sram_be_o(be_d),
        .sram_do_i(32'd0), .sram_di_o(di_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait slaves: ack one cycle after acceptance with dat = adr.
    logic       s_preq, d_preq;
    logic [9:0] s_padr, d_padr;
    int         s_acks = 0, s_err_at = 0;
    int         s_nreq = 0, s_nwr = 0;
    int         s_req_log[256], s_ad_log[256], s_di_log[256];
    int         d_nreq = 0, d_nwr = 0, d_last_req = 0, d_last_ad = 0, d_last_di = 0;

    always @(posedge clk) begin
        s_preq <= ws.cyc_o & ws.stb_o & ~ws.wat_i;
        s_padr <= ws.adr_o;
        d_preq <= wd.cyc_o & wd.stb_o & ~wd.wat_i;
        d_padr <= wd.adr_o;
        if (ws.cyc_o && ws.stb_o && !ws.wat_i && s_nreq < 256) begin
            s_req_log[s_nreq] <= int'(ws.adr_o);
            s_nreq <= s_nreq + 1;
        end
        if (ce_s && s_nwr < 256) begin
            s_ad_log[s_nwr] <= int'(ad_s);
            s_di_log[s_nwr] <= int'(di_s);
            s_nwr <= s_nwr + 1;
        end
        if (wd.cyc_o && wd.stb_o && !wd.wat_i) begin
            d_nreq <= d_nreq + 1;
            d_last_req <= int'(wd.adr_o);
        end
        if (ce_d) begin
            d_nwr <= d_nwr + 1;
            d_last_ad <= int'(ad_d);
            d_last_di <= int'(di_d);
        end
    end

    always @(negedge clk) begin
        ws.ack_i <= s_preq;
        ws.dat_i <= 32'(s_padr);
        ws.err_i <= s_preq && (s_acks + 1 == s_err_at);
        if (s_preq) s_acks <= s_acks + 1;
        wd.ack_i <= d_preq;
        wd.dat_i <= 32'(d_padr);
        wd.err_i <= 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_s();
        beg_s = 1'b1;
        @(negedge clk);
        beg_s = 1'b0;
    endtask

    task automatic wait_ready_s(input int lim);
        int n = 0;
        while (!ready_s && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("ready_in_time", 32'(ready_s), 32'd1);
    endtask

    task automatic chk_window(input string tag, input int br, input int bw);
        int exp_a[6] = '{0, 1, 2, 32, 33, 34};
        chk({tag, "_nreq"}, 32'(s_nreq - br), 32'd6);
        chk({tag, "_nwr"}, 32'(s_nwr - bw), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk({tag, "_adr"}, 32'(s_req_log[br + i]), 32'(exp_a[i]));
            chk({tag, "_sram_ad"}, 32'(s_ad_log[bw + i]), 32'(i));
            chk({tag, "_sram_di"}, 32'(s_di_log[bw + i]), 32'(exp_a[i]));
        end
    endtask

    initial begin
        int br, bw, n;
        rst_s = 1'b1; rst_d = 1'b1; beg_s = 1'b0; beg_d = 1'b0;
        ws.wat_i = 1'b0; ws.rty_i = 1'b0; wd.wat_i = 1'b0; wd.rty_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(ws.cyc_o), 32'd0);
        chk("rst_stb", 32'(ws.stb_o), 32'd0);
        chk("rst_ready", 32'(ready_s), 32'd0);
        chk("rst_ce", 32'(ce_s), 32'd0);
        chk("rst_adr", 32'(ws.adr_o), 32'd0);
        chk("rst_sram_ad", 32'(ad_s), 32'd0);
        chk("rst_sram_di", di_s, 32'd0);
        rst_s = 1'b0; rst_d = 1'b0;
        @(negedge clk);

        // basic window and exact ready latency (begin sampled at edge 1, ready after edge 9)
        br = s_nreq; bw = s_nwr;
        start_s();
        chk("a_we_const", 32'(ws.we_o), 32'd0);
        chk("a_sel", 32'(ws.sel_o), 32'hF);
        repeat (7) @(posedge clk);
        #1 chk("a_ready_edge8", 32'(ready_s), 32'd0);
        @(posedge clk);
        #1 chk("a_ready_edge9", 32'(ready_s), 32'd1);
        repeat (3) @(negedge clk);
        chk("a_ready_holds", 32'(ready_s), 32'd1);
        chk_window("a", br, bw);

        // stall for 4 cycles on the second request
        br = s_nreq; bw = s_nwr;
        start_s();
        @(posedge clk);
        @(negedge clk);
        ws.wat_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 chk("b_adr_hold", 32'(ws.adr_o), 32'd1);
        end
        @(negedge clk);
        ws.wat_i = 1'b0;
        wait_ready_s(40);
        chk_window("b", br, bw);

        // re-begin clears ready; a begin pulse while busy is ignored
        br = s_nreq; bw = s_nwr;
        start_s();
        chk("c_ready_clear", 32'(ready_s), 32'd0);
        repeat (2) @(negedge clk);
        beg_s = 1'b1;
        @(negedge clk);
        beg_s = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("c_ready_edge8", 32'(ready_s), 32'd0);
        @(posedge clk);
        #1 chk("c_ready_edge9", 32'(ready_s), 32'd1);
        repeat (4) @(negedge clk);
        chk_window("c", br, bw);

        // err (with a simultaneous ack) on the third response aborts the window
        br = s_nreq; bw = s_nwr;
        #1 s_err_at = s_acks + 3;
        start_s();
        n = 0;
        while (ws.cyc_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("d_cyc_drop", 32'(ws.cyc_o), 32'd0);
        chk("d_stb_drop", 32'(ws.stb_o), 32'd0);
        repeat (5) @(negedge clk);
        s_err_at = 0;
        chk("d_ready_low", 32'(ready_s), 32'd0);
        chk("d_nwr", 32'(s_nwr - bw), 32'd2);
        chk("d_ad0", 32'(s_ad_log[bw]), 32'd0);
        chk("d_ad1", 32'(s_ad_log[bw + 1]), 32'd1);
        chk("d_di1", 32'(s_di_log[bw + 1]), 32'd1);

        // async reset in the middle of a window, while an SRAM write is on the port
        start_s();
        @(posedge clk);
        @(posedge clk);
        #1 chk("e_ce_pre", 32'(ce_s), 32'd1);
        chk("e_we_eq_ce", 32'(we_s), 32'd1);
        chk("e_be", 32'(be_s), 32'hF);
        chk("e_cyc_pre", 32'(ws.cyc_o), 32'd1);
        #1 rst_s = 1'b1;
        #1 chk("e_cyc_rst", 32'(ws.cyc_o), 32'd0);
        chk("e_stb_rst", 32'(ws.stb_o), 32'd0);
        chk("e_ready_rst", 32'(ready_s), 32'd0);
        chk("e_ce_rst", 32'(ce_s), 32'd0);
        @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        br = s_nreq; bw = s_nwr;
        start_s();
        wait_ready_s(40);
        repeat (2) @(negedge clk);
        chk_window("f", br, bw);

        // default 24x24 window
        beg_d = 1'b1;
        @(negedge clk);
        beg_d = 1'b0;
        n = 1;
        while (!ready_d && n < 1000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("g_ready_edge", 32'(n), 32'd579);
        repeat (2) @(negedge clk);
        chk("g_nwr", 32'(d_nwr), 32'd576);
        chk("g_nreq", 32'(d_nreq), 32'd576);
        chk("g_last_ad", 32'(d_last_ad), 32'd575);
        chk("g_last_di", 32'(d_last_di), 32'((23 << 5) | 23));
        chk("g_last_adr", 32'(d_last_req), 32'((23 << 5) | 23));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
